// File: rtl/prach_pack.sv
// -----------------------------------------------------------------------------
// prach_pack
//   Packs a serial stream of complex PRACH FFT output samples (16-bit I/Q) into
//   128-bit Avalon-ST beats, four samples per beat. Each channel becomes one
//   packet of NUM_SC/4 beats. Packets are admitted only when the FIFO has room
//   for the whole packet. Otherwise they are dropped and counted. The FIFO is
//   store-and-forward: the read side only sees fully written packets.
//
// Ports
//   clk, rst_n                  DSP clock, asynchronous active-low reset
//   din_dr, din_di, din_dv      FFT output sample (real, imag) and its valid
//   sync_in                     start of symbol; coincides with chn 0 sample 0
//   avst_source_*               Avalon-ST source, ready latency 0
//                               channel = {symbol[7:0], 3'b0, chn[4:0]}
//   stat_drop_cnt               saturating count of dropped packets
// -----------------------------------------------------------------------------
module prach_pack #(
    parameter int NUM_SC     = 864,
    parameter int NUM_CHN    = 24,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  din_dr,
    input  logic [15:0]  din_di,
    input  logic         din_dv,
    input  logic         sync_in,
    output logic [127:0] avst_source_data,
    output logic         avst_source_valid,
    input  logic         avst_source_ready,
    output logic [15:0]  avst_source_channel,
    output logic         avst_source_startofpacket,
    output logic         avst_source_endofpacket,
    output logic [15:0]  stat_drop_cnt
);

    localparam int BPP = NUM_SC / 4;                 // beats per packet
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;                     // pointers carry a wrap bit
    localparam int SCW = $clog2(NUM_SC);

    typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

    typedef struct packed {
        logic [15:0]  chan;
        logic         sop;
        logic         eop;
        logic [127:0] data;
    } entry_t;

    // ------------------------------------------------------------------ state
    state_t         state;
    logic [SCW-1:0] sc_cnt;
    logic [4:0]     chn_cnt;
    logic [7:0]     sym_cnt;
    logic           sym_seen;       // a sync_in has been seen since reset
    logic [95:0]    lanes;          // samples 0..2 of the beat being built
    logic [15:0]    pkt_chan;
    logic [PW-1:0]  wr_ptr;         // speculative write pointer
    logic [PW-1:0]  commit_ptr;     // end of the last complete packet
    logic [PW-1:0]  rd_ptr;

    entry_t         mem [FIFO_DEPTH];
    entry_t         m_entry;        // memory read register
    logic           m_valid;

    // ------------------------------------------------------------ write side
    logic           take;
    logic           at_admit;
    logic           room;
    logic           accepting;
    logic           wr_en;
    logic           last_sc;
    logic           last_chn;
    logic [SCW-1:0] sc_idx;
    logic [4:0]     chn_idx;
    logic [7:0]     sym_next;
    logic [15:0]    chan_now;
    logic [PW-1:0]  wr_base;
    logic [PW-1:0]  used;
    entry_t         wr_entry;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        // sync_in restarts the symbol: the current sample is chn 0 sample 0
        // and any uncommitted beats are abandoned before admission is judged.
        sc_idx   = sync_in ? '0 : sc_cnt;
        chn_idx  = sync_in ? '0 : chn_cnt;
        wr_base  = sync_in ? commit_ptr : wr_ptr;
        sym_next = sym_cnt;
        if (sync_in) begin
            sym_next = sym_seen ? sym_cnt + 8'd1 : 8'd0;
        end

        take      = sync_in || (state != IDLE && din_dv);
        at_admit  = take && (sc_idx == '0);
        used      = wr_base - rd_ptr;
        room      = used <= PW'(FIFO_DEPTH - BPP);
        accepting = at_admit ? room : (state == ACCEPT);
        last_sc   = sc_idx == SCW'(NUM_SC - 1);
        last_chn  = chn_idx == 5'(NUM_CHN - 1);
        chan_now  = at_admit ? {sym_next, 3'b000, chn_idx} : pkt_chan;
        wr_en     = take && accepting && (sc_idx[1:0] == 2'd3);

        wr_entry      = '0;
        wr_entry.chan = chan_now;
        wr_entry.sop  = sc_idx == SCW'(3);
        wr_entry.eop  = last_sc;
        wr_entry.data = {din_dr, din_di, lanes};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sc_cnt        <= '0;
            chn_cnt       <= '0;
            sym_cnt       <= '0;
            sym_seen      <= 1'b0;
            lanes         <= '0;
            pkt_chan      <= '0;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            stat_drop_cnt <= '0;
        end else if (take) begin
            sym_cnt <= sym_next;
            if (sync_in) begin
                sym_seen <= 1'b1;
            end
            if (at_admit) begin
                pkt_chan <= chan_now;
                if (!room && stat_drop_cnt != 16'hFFFF) begin
                    stat_drop_cnt <= stat_drop_cnt + 16'd1;
                end
            end

            if (wr_en) begin
                wr_ptr <= wr_base + PW'(1);
                if (last_sc) begin
                    commit_ptr <= wr_base + PW'(1);
                end
            end else begin
                wr_ptr <= wr_base;
            end

            if (accepting) begin
                case (sc_idx[1:0])
                    2'd0:    lanes[31:0]  <= {din_dr, din_di};
                    2'd1:    lanes[63:32] <= {din_dr, din_di};
                    2'd2:    lanes[95:64] <= {din_dr, din_di};
                    default: ;
                endcase
            end

            if (last_sc) begin
                sc_cnt <= '0;
                if (last_chn) begin
                    chn_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    chn_cnt <= chn_idx + 5'd1;
                    state   <= accepting ? ACCEPT : DISCARD;
                end
            end else begin
                sc_cnt  <= sc_idx + SCW'(1);
                chn_cnt <= chn_idx;
                state   <= accepting ? ACCEPT : DISCARD;
            end
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers empties the
    // FIFO, and leaving the array unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // ------------------------------------------------------------- read side
    // Two-stage show-ahead: memory read register feeding the output register.
    // A slot is refilled in the same cycle it is emptied, giving one beat per
    // cycle under continuous ready.
    logic out_load;
    logic rd_en;

    always_comb begin
        out_load = m_valid && (!avst_source_valid || avst_source_ready);
        rd_en    = (rd_ptr != commit_ptr) && (!m_valid || out_load);
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            m_entry <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr                    <= '0;
            m_valid                   <= 1'b0;
            avst_source_valid         <= 1'b0;
            avst_source_data          <= '0;
            avst_source_channel       <= '0;
            avst_source_startofpacket <= 1'b0;
            avst_source_endofpacket   <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr  <= rd_ptr + PW'(1);
                m_valid <= 1'b1;
            end else if (out_load) begin
                m_valid <= 1'b0;
            end

            if (out_load) begin
                avst_source_valid         <= 1'b1;
                avst_source_data          <= m_entry.data;
                avst_source_channel       <= m_entry.chan;
                avst_source_startofpacket <= m_entry.sop;
                avst_source_endofpacket   <= m_entry.eop;
            end else if (avst_source_ready) begin
                avst_source_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prach_pack.sv
// -----------------------------------------------------------------------------
// tb_prach_pack
//   Self-checking bench for prach_pack. A driver streams symbols of samples; a
//   reference model turns each admitted channel into its expected beats and
//   queues them; a monitor pops and compares every transferred beat, and checks
//   that valid/data hold while stalled and that packets are framed correctly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prach_pack;

    localparam int NUM_SC     = 864;
    localparam int NUM_CHN    = 24;
    localparam int FIFO_DEPTH = 1024;
    localparam int BPP        = NUM_SC / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  din_dr = '0;
    logic [15:0]  din_di = '0;
    logic         din_dv = 1'b0;
    logic         sync_in = 1'b0;
    logic [127:0] avst_source_data;
    logic         avst_source_valid;
    logic         avst_source_ready = 1'b0;
    logic [15:0]  avst_source_channel;
    logic         avst_source_startofpacket;
    logic         avst_source_endofpacket;
    logic [15:0]  stat_drop_cnt;

    prach_pack #(.NUM_SC(NUM_SC), .NUM_CHN(NUM_CHN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .din_dr                    (din_dr),
        .din_di                    (din_di),
        .din_dv                    (din_dv),
        .sync_in                   (sync_in),
        .avst_source_data          (avst_source_data),
        .avst_source_valid         (avst_source_valid),
        .avst_source_ready         (avst_source_ready),
        .avst_source_channel       (avst_source_channel),
        .avst_source_startofpacket (avst_source_startofpacket),
        .avst_source_endofpacket   (avst_source_endofpacket),
        .stat_drop_cnt             (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]  chan;
        logic         sop;
        logic         eop;
        logic [127:0] data;
    } beat_t;

    int           n_checks = 0;
    int           n_fail   = 0;

    beat_t        exp_q[$];
    logic [15:0]  sop_chan_log[$];
    logic [127:0] sop_data_log[$];
    int           pushed = 0;
    int           popped = 0;
    int           m_drops = 0;
    logic [7:0]   m_sym = '0;
    bit           m_seen = 1'b0;
    int           ready_mode = 0;   // 0: low, 1: high, 2: random 50%

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pushed  = 0;
        popped  = 0;
        m_drops = 0;
        m_sym   = '0;
        m_seen  = 1'b0;
    endtask

    // Ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       avst_source_ready = 1'b0;
                1:       avst_source_ready = 1'b1;
                default: avst_source_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Output monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit    prev_stall = 1'b0;
        bit    in_pkt = 1'b0;
        beat_t prev_word = '0;
        beat_t cur;
        beat_t expb;
        forever begin
            @(negedge clk);
            cur = '{chan: avst_source_channel, sop: avst_source_startofpacket,
                    eop: avst_source_endofpacket, data: avst_source_data};
            if (!rst_n) begin
                prev_stall = 1'b0;
                in_pkt     = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 160'(avst_source_valid), 160'(1));
                    check("stall_beat", 160'(cur), 160'(prev_word));
                end
                if (avst_source_valid && avst_source_ready) begin
                    check("beat_expected", 160'(exp_q.size() > 0), 160'(1));
                    if (exp_q.size() > 0) begin
                        expb = exp_q.pop_front();
                        check("beat", 160'(cur), 160'(expb));
                    end
                    if (cur.sop) begin
                        check("sop_inside_packet", 160'(in_pkt), 160'(0));
                        sop_chan_log.push_back(cur.chan);
                        sop_data_log.push_back(cur.data);
                    end
                    in_pkt = !cur.eop;
                    popped++;
                end
                prev_stall = avst_source_valid && !avst_source_ready;
                prev_word  = cur;
            end
        end
    end

    // Drives one symbol from chn 0 sample 0, stopping before (stop_chn, stop_sc).
    // The model admits a packet when the buffer holds room for a whole packet;
    // under back-pressure two beats sit in the output stage outside the buffer.
    task automatic run_symbol(input int stop_chn, input int stop_sc,
                              input int gap_pct, input bit rnd);
        logic [31:0] samp[$];
        bit          acc = 1'b0;
        int          outstanding;
        int          used;
        int          n;
        logic [15:0] dr;
        logic [15:0] di;
        beat_t       b;
        for (int c = 0; c < NUM_CHN; c++) begin
            for (int s = 0; s < NUM_SC; s++) begin
                if (c == stop_chn && s == stop_sc) return;
                if (s == 0) begin
                    if (c == 0) begin
                        m_sym  = m_seen ? m_sym + 8'd1 : 8'd0;
                        m_seen = 1'b1;
                    end
                    outstanding = pushed - popped;
                    used = (outstanding > 2) ? outstanding - 2 : 0;
                    acc  = (FIFO_DEPTH - used) >= BPP;
                    if (!acc && m_drops < 65535) m_drops++;
                    samp.delete();
                end
                if (rnd) begin
                    dr = 16'($urandom);
                    di = 16'($urandom);
                end else begin
                    n  = c * NUM_SC + s;
                    dr = 16'(n);
                    di = 16'(-n);
                end
                while (int'($urandom_range(99)) < gap_pct) begin
                    din_dv = 1'b0;
                    din_dr = 16'($urandom);
                    @(posedge clk);
                    #1;
                end
                din_dv  = 1'b1;
                sync_in = (c == 0 && s == 0);
                din_dr  = dr;
                din_di  = di;
                @(posedge clk);
                #1;
                din_dv  = 1'b0;
                sync_in = 1'b0;
                if (acc) samp.push_back({dr, di});
                if (acc && s == NUM_SC - 1) begin
                    for (int j = 0; j < BPP; j++) begin
                        b.chan = {m_sym, 3'b000, 5'(c)};
                        b.sop  = (j == 0);
                        b.eop  = (j == BPP - 1);
                        b.data = {samp[4*j+3], samp[4*j+2], samp[4*j+1], samp[4*j]};
                        exp_q.push_back(b);
                    end
                    pushed += BPP;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 160'(exp_q.size()), 160'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 160'(avst_source_valid), 160'(0));
        check("rst_sop_eop", 160'({avst_source_startofpacket, avst_source_endofpacket}), 160'(0));
        check("rst_data", 160'(avst_source_data), 160'(0));
        check("rst_chan", 160'(avst_source_channel), 160'(0));
        check("rst_drop", 160'(stat_drop_cnt), 160'(0));
        rst_n = 1'b1;

        // Ramp symbol with continuous ready.
        ready_mode = 1;
        sop_chan_log.delete();
        sop_data_log.delete();
        run_symbol(NUM_CHN, 0, 0, 1'b0);
        drain(2000);
        check("ramp_packets", 160'(sop_chan_log.size()), 160'(24));
        check("ramp_beat0", 160'(sop_data_log[0]), 160'(128'h0003FFFD_0002FFFE_0001FFFF_00000000));
        check("ramp_chan_first", 160'(sop_chan_log[0]), 160'(16'h0000));
        check("ramp_chan_last", 160'(sop_chan_log[23]), 160'(16'h0017));
        check("ramp_drop", 160'(stat_drop_cnt), 160'(0));

        // Whole symbol against a stalled sink: FIFO fills, later channels drop.
        ready_mode = 0;
        run_symbol(NUM_CHN, 0, 0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("full_drop_cnt", 160'(stat_drop_cnt), 160'(20));
        check("full_drop_model", 160'(stat_drop_cnt), 160'(m_drops));
        check("full_hold_valid", 160'(avst_source_valid), 160'(1));
        sop_chan_log.delete();
        ready_mode = 1;
        drain(3000);
        check("full_packets", 160'(sop_chan_log.size()), 160'(4));

        // sync_in mid-packet: chn 5 is lost, next packet is symbol 1 chn 0.
        apply_reset();
        run_symbol(5, 400, 0, 1'b1);
        drain(3000);
        sop_chan_log.delete();
        run_symbol(1, 0, 0, 1'b1);
        drain(2000);
        check("abort_packets", 160'(sop_chan_log.size()), 160'(1));
        check("abort_next_chan", 160'(sop_chan_log[0]), 160'(16'h0100));

        // Random input gaps and random ready.
        ready_mode = 2;
        run_symbol(3, 0, 30, 1'b1);
        drain(6000);

        // Latency with empty FIFO and ready high.
        ready_mode = 1;
        run_symbol(1, 0, 0, 1'b1);
        check("lat_cycle1", 160'(avst_source_valid), 160'(0));
        @(posedge clk);
        #1;
        check("lat_cycle2", 160'(avst_source_valid), 160'(0));
        @(posedge clk);
        #1;
        check("lat_cycle3", 160'({avst_source_valid, avst_source_startofpacket}), 160'(2'b11));
        drain(1000);

        // Reset pulse while chn 2 is being output.
        run_symbol(3, 100, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", 160'(avst_source_valid), 160'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            din_dv = 1'($urandom);
            din_dr = 16'($urandom);
            din_di = 16'($urandom);
            @(posedge clk);
            #1;
            if (avst_source_valid) vcount++;
        end
        din_dv = 1'b0;
        check("idle_after_reset", 160'(vcount), 160'(0));
        check("drop_after_reset", 160'(stat_drop_cnt), 160'(0));
        sop_chan_log.delete();
        run_symbol(1, 0, 0, 1'b1);
        drain(1000);
        check("post_reset_chan", 160'(sop_chan_log[0]), 160'(16'h0000));

        // Symbol counter wrap: 270 bare syncs, then one packet.
        apply_reset();
        for (int i = 0; i < 270; i++) begin
            run_symbol(0, 1, 0, 1'b1);
        end
        sop_chan_log.delete();
        run_symbol(1, 0, 0, 1'b1);
        drain(1000);
        check("wrap_chan", 160'(sop_chan_log[0]), 160'(16'h0E00));
        check("drop_final", 160'(stat_drop_cnt), 160'(m_drops));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
